// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Streams one sprite from a synchronous sprite ROM to the VGA adapter write
//   port. The sprite is walked in raster order, one ROM address per cycle.
//   Each pixel is translated to screen coordinates at the origin latched with
//   start. Transparent and off-screen pixels are not plotted. In erase mode
//   every opaque pixel is repainted in BG_COLOUR.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high reset
//   start       request pulse, accepted only when idle
//   base_x/y    sprite top-left corner, latched on an accepted start
//   erase       1 = paint BG_COLOUR over the opaque footprint, latched on start
//   rom_addr    sprite ROM read address (row*SPRITE_W + col)
//   rom_data    ROM colour, valid one cycle after rom_addr
//   out_x/y     pixel coordinates to the VGA adapter
//   out_colour  pixel colour to the VGA adapter
//   plot        write strobe, at most one pixel per cycle
//   busy        high while a sprite is in progress (RUN and DRAIN)
//   done        one-cycle completion pulse
module sprite_blitter #(
  parameter int         SPRITE_W    = 32,
  parameter int         SPRITE_H    = 32,
  parameter int         ADDR_W      = 10,
  parameter logic [2:0] TRANSPARENT = 3'b101,
  parameter logic [2:0] BG_COLOUR   = 3'b111,
  parameter int         SCREEN_W    = 320,
  parameter int         SCREEN_H    = 240
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [8:0]        base_x,
  input  logic [7:0]        base_y,
  input  logic              erase,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [8:0]        out_x,
  output logic [7:0]        out_y,
  output logic [2:0]        out_colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int N     = SPRITE_W * SPRITE_H;
  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Issue side: linear address counter plus col/row kept in step with it,
  // so no multiplier is needed for row*SPRITE_W + col.
  logic [ADDR_W-1:0] addr_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              drain_cnt_reg;

  // Request parameters held for the whole sprite.
  logic [8:0] base_x_reg;
  logic [7:0] base_y_reg;
  logic       erase_reg;

  // Stage 1: travels alongside the ROM read, lines up with rom_data.
  logic             s1_valid_reg;
  logic [COL_W-1:0] s1_col_reg;
  logic [ROW_W-1:0] s1_row_reg;

  // Stage 2: registered pixel outputs.
  logic [8:0] out_x_reg;
  logic [7:0] out_y_reg;
  logic [2:0] out_colour_reg;
  logic       plot_reg;

  logic       last_addr;
  logic       last_col;
  logic [9:0] sx;
  logic [8:0] sy;
  logic       clipped;

  assign last_addr = (addr_reg == ADDR_W'(N - 1));
  assign last_col  = (col_reg == COL_W'(SPRITE_W - 1));

  // Screen coordinates are formed one bit wider than the screen range so a
  // pixel running off the right/bottom edge is clipped instead of wrapping.
  assign sx      = 10'(base_x_reg) + 10'(s1_col_reg);
  assign sy      = 9'(base_y_reg) + 9'(s1_row_reg);
  assign clipped = (sx >= 10'(SCREEN_W)) || (sy >= 9'(SCREEN_H));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_addr) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_reg) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg       <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      drain_cnt_reg  <= 1'b0;
      base_x_reg     <= '0;
      base_y_reg     <= '0;
      erase_reg      <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s1_col_reg     <= '0;
      s1_row_reg     <= '0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      out_colour_reg <= '0;
      plot_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            base_x_reg <= base_x;
            base_y_reg <= base_y;
            erase_reg  <= erase;
            addr_reg   <= '0;
            col_reg    <= '0;
            row_reg    <= '0;
          end
        end
        S_RUN: begin
          // Return the counters to zero after the final address so the ROM
          // address rests at 0 between sprites.
          if (last_addr) begin
            addr_reg <= '0;
            col_reg  <= '0;
            row_reg  <= '0;
          end else begin
            addr_reg <= addr_reg + 1'b1;
            if (last_col) begin
              col_reg <= '0;
              row_reg <= row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Second DRAIN cycle is marked by this flag.
      drain_cnt_reg <= (state_reg == S_DRAIN);

      s1_valid_reg <= (state_reg == S_RUN);
      s1_col_reg   <= col_reg;
      s1_row_reg   <= row_reg;

      // Transparency is judged on the ROM colour even in erase mode, so the
      // erase footprint is exactly the drawn footprint.
      plot_reg       <= s1_valid_reg && !clipped && (rom_data != TRANSPARENT);
      out_x_reg      <= sx[8:0];
      out_y_reg      <= sy[7:0];
      out_colour_reg <= erase_reg ? BG_COLOUR : rom_data;
    end
  end

  assign rom_addr   = addr_reg;
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign out_colour = out_colour_reg;
  assign plot       = plot_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a behavioural synchronous ROM, a
// raster-order list of expected plots per sprite, and hand-computed checks on
// counts, first/last pixels and completion timing. Cycle 0 is the cycle in
// which start is driven high.
module tb_sprite_blitter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  base_x;
  logic [7:0]  base_y;
  logic        erase;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_data;
  logic [8:0]  out_x;
  logic [7:0]  out_y;
  logic [2:0]  out_colour;
  logic        plot;
  logic        busy;
  logic        done;

  logic [2:0] rom_mem [0:1023];

  int total = 0;
  int bad   = 0;

  // Results gathered by run_sprite
  int exp_q[$];
  int n_plot, first_cyc, first_x, first_y, first_c, last_x, last_y;
  int done_cnt, done_cyc, busy_at_done, plot_at_done, busy_pre;
  int pix_err, odd_x, at_origin, out_win, max_x, max_y, post_rst_act;

  sprite_blitter dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_x     (base_x),
    .base_y     (base_y),
    .erase      (erase),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #10 clock = ~clock;

  always @(posedge clock) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // mode 0: all 3'b100; mode 1: transparent at 0 and odd addresses, else 3'b010;
  // mode 2: colour = low three address bits (every 8th is transparent).
  task automatic set_rom(input int mode);
    for (int a = 0; a < 1024; a++) begin
      case (mode)
        0: rom_mem[a] = 3'b100;
        1: rom_mem[a] = (a == 0 || (a % 2) == 1) ? 3'b101 : 3'b010;
        default: rom_mem[a] = 3'(a % 8);
      endcase
    end
  endtask

  task automatic run_sprite(input int bx, input int by, input logic er,
                            input int reset_at, input bit repulse);
    int sx, sy, c, got, e;
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < 32; k++) begin
        sx = bx + k;
        sy = by + r;
        if (sx < 320 && sy < 240 && rom_mem[r * 32 + k] != 3'b101) begin
          c = er ? 7 : int'(rom_mem[r * 32 + k]);
          exp_q.push_back((sx << 11) | (sy << 3) | c);
        end
      end
    end
    n_plot = 0; first_cyc = -1; first_x = -1; first_y = -1; first_c = -1;
    last_x = -1; last_y = -1; done_cnt = 0; done_cyc = -1;
    busy_at_done = -1; plot_at_done = -1; busy_pre = -1; pix_err = 0;
    odd_x = 0; at_origin = 0; out_win = 0; max_x = 0; max_y = 0;
    post_rst_act = 0;

    base_x = 9'(bx);
    base_y = 8'(by);
    erase  = er;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      if (plot) begin
        got = (int'(out_x) << 11) | (int'(out_y) << 3) | int'(out_colour);
        if (exp_q.size() == 0) begin
          pix_err++;
        end else begin
          e = exp_q.pop_front();
          if (got != e) pix_err++;
        end
        if (n_plot == 0) begin
          first_cyc = cyc; first_x = out_x; first_y = out_y; first_c = out_colour;
        end
        n_plot++;
        last_x = out_x;
        last_y = out_y;
        if (out_x[0]) odd_x++;
        if (out_x == 0 && out_y == 0) at_origin++;
        if (int'(out_x) < bx || int'(out_y) < by) out_win++;
        if (int'(out_x) > max_x) max_x = out_x;
        if (int'(out_y) > max_y) max_y = out_y;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
        plot_at_done = plot;
      end
      if (cyc == 1026) busy_pre = busy;
      if (reset_at > 0 && cyc > reset_at && (plot || busy || done)) post_rst_act++;

      reset = (reset_at > 0 && cyc == reset_at);
      if (repulse && (cyc == 100 || cyc == 500)) begin
        start  = 1'b1;
        base_x = 9'd50;
        base_y = 8'd60;
        erase  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    base_x = '0;
    base_y = '0;
    erase  = 1'b0;
    set_rom(0);
    step();
    step();
    start = 1'b0;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      check("idle_rom_addr", int'(rom_addr), 0);
      check("idle_plot", int'(plot), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      step();
    end

    // Fully opaque sprite at (10,20)
    set_rom(0);
    run_sprite(10, 20, 1'b0, 0, 1'b0);
    check("opq_first_cyc", first_cyc, 3);
    check("opq_first_x", first_x, 10);
    check("opq_first_y", first_y, 20);
    check("opq_first_c", first_c, 4);
    check("opq_count", n_plot, 1024);
    check("opq_last_x", last_x, 41);
    check("opq_last_y", last_y, 51);
    check("opq_done_cnt", done_cnt, 1);
    check("opq_done_cyc", done_cyc, 1027);
    check("opq_busy_at_done", busy_at_done, 0);
    check("opq_plot_at_done", plot_at_done, 0);
    check("opq_busy_last_px", busy_pre, 1);
    check("opq_pixels", pix_err, 0);
    check("opq_idle_addr", int'(rom_addr), 0);

    // Erase with a checkerboard-column transparency pattern
    set_rom(1);
    run_sprite(0, 0, 1'b1, 0, 1'b0);
    check("ers_count", n_plot, 511);
    check("ers_odd_x", odd_x, 0);
    check("ers_origin", at_origin, 0);
    check("ers_pixels", pix_err, 0);
    check("ers_done_cyc", done_cyc, 1027);

    // Right/bottom clip
    set_rom(0);
    run_sprite(300, 230, 1'b0, 0, 1'b0);
    check("clip_count", n_plot, 200);
    check("clip_wrap", out_win, 0);
    check("clip_max_x", max_x, 319);
    check("clip_max_y", max_y, 239);
    check("clip_pixels", pix_err, 0);
    check("clip_done_cyc", done_cyc, 1027);

    // start re-pulsed mid-sprite with a new base and erase
    run_sprite(10, 20, 1'b0, 0, 1'b1);
    check("rep_count", n_plot, 1024);
    check("rep_pixels", pix_err, 0);
    check("rep_done_cnt", done_cnt, 1);
    check("rep_done_cyc", done_cyc, 1027);

    // Reset mid-sprite, then a full fresh sprite
    run_sprite(10, 20, 1'b0, 400, 1'b0);
    check("rst_quiet", post_rst_act, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_pixels", pix_err, 0);
    set_rom(2);
    run_sprite(5, 7, 1'b0, 0, 1'b0);
    check("new_count", n_plot, 896);
    check("new_first_c", first_c, 0);
    check("new_pixels", pix_err, 0);
    check("new_done_cnt", done_cnt, 1);
    check("new_done_cyc", done_cyc, 1027);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Pixel-stream generator that feeds the VGA adapter's write port (x, y, colour, plot) for one sprite per request.
- On `start` it walks a SPRITE_W x SPRITE_H sprite ROM in raster order, translates each pixel to screen coordinates at a latched origin, and emits one plot per cycle.
- Transparent and off-screen pixels are skipped.
- Erase mode repaints the sprite footprint in background colour, giving the draw/erase/move animation loop a single reusable drawer per character.

Parameters:
- SPRITE_W, 32, sprite width in pixels (1..64).
- SPRITE_H, 32, sprite height in pixels (1..64).
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H.
- TRANSPARENT, 3'b101, ROM colour code that is never plotted.
- BG_COLOUR, 3'b111, colour written in erase mode.
- SCREEN_W, 320, horizontal clip limit.
- SCREEN_H, 240, vertical clip limit.

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- base_x  in  9  sprite top-left x; latched on accepted start
- base_y  in  8  sprite top-left y; latched on accepted start
- erase  in  1  1 = paint BG_COLOUR over the footprint; latched on accepted start
- rom_addr  out  ADDR_W  sprite ROM read address, raster order
- rom_data  in  3  ROM colour; synchronous ROM, valid exactly 1 cycle after rom_addr
- out_x  out  9  pixel x to VGA adapter
- out_y  out  8  pixel y to VGA adapter
- out_colour  out  3  pixel colour to VGA adapter
- plot  out  1  write strobe, one pixel per cycle
- busy  out  1  high while a sprite is in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE; rom_addr = 0, out_x = 0, out_y = 0, out_colour = 0; plot, busy and done all 0. Reset wins over every other input.
- States and transitions:
  - IDLE → RUN on start=1. The block latches base_x, base_y and erase, and clears col, row and the linear address to 0.
  - RUN: issues one address per cycle, rom_addr = row*SPRITE_W + col, using a linear counter rather than a multiplier.
    - col wraps at SPRITE_W-1 → 0 and increments row.
    - After issuing address N-1 (N = SPRITE_W*SPRITE_H), go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then DONE.
  - DONE: 1 cycle with done=1, then IDLE.
- Pipeline:
  - Stage 1 registers valid, col and row alongside the address.
  - Stage 2 registers the outputs from rom_data.
  - Pixel issued in RUN cycle k (first RUN cycle = 0) has plot/out_* valid in cycle k+2.
- Timing relative to the first RUN cycle:
  - Last pixel is output in cycle N+1.
  - done=1 in cycle N+2, with plot=0 that cycle.
  - busy=1 from cycle 0 through cycle N+1; busy=0 in DONE and IDLE.
  - An accepted start in cycle t gives the first RUN cycle at t+1.
- Coordinate arithmetic:
  - sx = base_x + col, computed 10 bits wide.
  - sy = base_y + row, computed 9 bits wide.
  - Pixel is clipped (plot=0) if sx >= SCREEN_W or sy >= SCREEN_H. No wrap-around onto the opposite edge.
- Plot rule: plot = stage1 valid AND not clipped AND rom_data != TRANSPARENT. This holds in both modes, so erase never touches pixels outside the opaque footprint.
- Colour: out_colour = BG_COLOUR when latched erase = 1, else rom_data. out_x and out_y take the low 9/8 bits of sx/sy. When plot=0, out_* may hold any value.
- start while busy or in DONE: ignored, with no queuing. start in the same cycle as reset: ignored.
- Changing base_x, base_y or erase mid-sprite has no effect.
- Reset mid-sprite: next cycle plot=0 and busy=0, and done is not pulsed.
- Throughput: one pixel per cycle. The VGA adapter accepts a write every cycle, so there is no backpressure.

Test Plan:
- Reset, then 5 idle cycles → rom_addr=0, plot=0, busy=0, done=0 throughout.
- Fully opaque ROM (all 3'b100), base (10,20), start in cycle 0 → first plot in cycle 3 at (10,20) colour 3'b100; exactly 1024 plots in raster order; last at (41,51); done pulses once in cycle 1027; busy low in that cycle.
- ROM with TRANSPARENT at address 0 and every odd address, erase=1, base (0,0) → 511 plots, all colour 3'b111, none at odd x positions or at (0,0).
- Right/bottom clip: base (300,230) → plots only where x ≤ 319 and y ≤ 239 (20x10 = 200 plots), no wrap to x<300 or y<230; done still in cycle 1027.
- start re-pulsed at cycles 100 and 500 of an active sprite, with base changed → ignored; output coordinates still use the original base; a single done.
- reset asserted in cycle 400 of an active sprite → plot and busy low from cycle 401, no done; a new start afterwards renders a full sprite correctly.
